// File: rtl/fluxo_dados_rodadas.sv
// Datapath for the memory-sequence game: sequence memory, position/round counters,
// jogada register, mode register, timeout counter and the switch edge detector.
module fluxo_dados_rodadas #(
    parameter int unsigned W         = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT_M = 3000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [W-1:0]               chaves,
    input  logic [1:0]                 modo,
    input  logic                       registra_modo,
    input  logic                       zeraE,
    input  logic                       contaE,
    input  logic                       zeraL,
    input  logic                       contaL,
    input  logic                       zeraR,
    input  logic                       registraR,
    input  logic                       escreveM,
    input  logic                       zera_timeout,
    input  logic                       conta_timeout,
    output logic                       igual,
    output logic                       enderecoIgualLimite,
    output logic                       fimE,
    output logic                       fimL,
    output logic                       jogada_feita,
    output logic                       jogada_valida,
    output logic                       timeout,
    output logic [$clog2(DEPTH)-1:0]   db_endereco,
    output logic [$clog2(DEPTH)-1:0]   db_limite,
    output logic [W-1:0]               db_jogada,
    output logic [W-1:0]               db_memoria,
    output logic [1:0]                 db_modo
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_M);
    localparam int unsigned MB = DEPTH * W;
    localparam int unsigned MW = $clog2(MB);

    // Power-up pattern: word i holds a single bit at position i mod W.
    function automatic logic [MB-1:0] init_pattern();
        logic [MB-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v[i * W + (i % W)] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [MB-1:0] INIT_FLAT = init_pattern();

    logic [MB-1:0]  mem_flat = INIT_FLAT;
    logic [AW-1:0]  endereco;
    logic [AW-1:0]  limite;
    logic [W-1:0]   jogada;
    logic [W-1:0]   dado;
    logic [1:0]     modo_reg;
    logic [TW-1:0]  tcount;
    logic           prev_tem_jogada;
    logic [AW-1:0]  last_pos;
    logic [MW-1:0]  base;

    assign base     = MW'(endereco) * MW'(W);
    assign last_pos = AW'((DEPTH >> modo_reg) - 1);

    // Memory is not touched by reset so a written sequence survives it.
    always_ff @(posedge clock) begin
        if (!reset && escreveM) begin
            mem_flat[base +: W] <= jogada;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            endereco        <= '0;
            limite          <= '0;
            jogada          <= '0;
            dado            <= '0;
            modo_reg        <= '0;
            tcount          <= '0;
            prev_tem_jogada <= 1'b0;
        end else begin
            dado            <= mem_flat[base +: W];
            prev_tem_jogada <= |chaves;

            if (zeraE)       endereco <= '0;
            else if (contaE) endereco <= endereco + AW'(1);

            if (zeraL)       limite <= '0;
            else if (contaL) limite <= limite + AW'(1);

            if (zeraR)          jogada <= '0;
            else if (registraR) jogada <= chaves;

            if (registra_modo) modo_reg <= modo;

            if (zera_timeout) begin
                tcount <= '0;
            end else if (conta_timeout) begin
                if (tcount == TW'(TIMEOUT_M - 1)) tcount <= '0;
                else                              tcount <= tcount + TW'(1);
            end
        end
    end

    assign igual               = (dado == jogada);
    assign enderecoIgualLimite = (endereco == limite);
    assign fimE                = (endereco == last_pos);
    assign fimL                = (limite == last_pos);
    assign jogada_feita        = (|chaves) & ~prev_tem_jogada;
    assign jogada_valida       = $onehot(chaves);
    assign timeout             = (tcount == TW'(TIMEOUT_M - 1));

    assign db_endereco = endereco;
    assign db_limite   = limite;
    assign db_jogada   = jogada;
    assign db_memoria  = dado;
    assign db_modo     = modo_reg;

endmodule
